// File: rtl/npu_pool_requant.sv
// npu_pool_requant: 2x2 max-pool, ReLU and requantization of signed accumulator
// rows into N-bit unsigned activations. Even rows are parked in a one-row line
// buffer (after the horizontal max). Odd rows are combined with it and emitted
// through a single output register.
// Optional build macro: NPU_POOL_ROUND_EN selects round-half-up requantization
// instead of a truncating right shift.
module npu_pool_requant #(
    parameter int W         = 8,
    parameter int N         = 2,
    parameter int BG        = 6,
    parameter int ROW_BEATS = 4,
    parameter int ROWS      = 28
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [3:0]                  cfg_shift,
    input  logic                        s_valid,
    output logic                        s_ready,
    input  logic [W*(2*N+BG)-1:0]       s_data,
    output logic                        m_valid,
    input  logic                        m_ready,
    output logic [(W/2)*N-1:0]          m_data,
    output logic                        frame_done
);
    localparam int ACC_W = 2*N + BG;
    localparam int HW    = W / 2;
    localparam int QW    = ACC_W + 1;
    localparam int CW    = (ROW_BEATS > 1) ? $clog2(ROW_BEATS) : 1;
    localparam int RW    = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int LB_D  = 1 << CW;
    localparam logic [CW-1:0] COL_LAST = CW'(ROW_BEATS - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
    localparam logic [QW-1:0] QMAX     = QW'((1 << N) - 1);

    generate
        if ((ROWS % 2) != 0) begin : g_rows_odd
            $error("npu_pool_requant: ROWS must be even");
        end
        if ((W % 2) != 0) begin : g_w_odd
            $error("npu_pool_requant: W must be even");
        end
    endgenerate

    // Row parity is the whole state machine: even rows fill, odd rows emit.
    typedef enum logic {FILL = 1'b0, EMIT = 1'b1} state_e;

    // ReLU, right shift (optionally rounded) and saturation to 2^N-1.
    // The value is known positive past the ReLU, so the work is done unsigned
    // in ACC_W+1 bits where the rounding add cannot overflow.
    function automatic logic [N-1:0] requant(input logic signed [ACC_W-1:0] v,
                                             input logic [3:0] sh);
        logic [QW-1:0] mag;
        logic [QW-1:0] q;
        if (v[ACC_W-1] || (v == '0)) begin
            return '0;
        end
        mag = {1'b0, v};
`ifdef NPU_POOL_ROUND_EN
        if (sh != 4'd0) begin
            mag = mag + ({{ACC_W{1'b0}}, 1'b1} << (sh - 4'd1));
        end
`endif
        q = mag >> sh;
        if (q > QMAX) begin
            return QMAX[N-1:0];
        end
        return q[N-1:0];
    endfunction

    logic [CW-1:0]           col_q, col_d;
    logic [RW-1:0]           row_q, row_d;
    logic [3:0]              shift_frame_q, shift_frame_d;
    logic                    m_valid_q, m_valid_d;
    logic [HW*N-1:0]         m_data_q, m_data_d;
    logic                    last_q, last_d;
    logic signed [ACC_W-1:0] lb_q [LB_D][HW];
    logic signed [ACC_W-1:0] hmax [HW];
    logic signed [ACC_W-1:0] vmax [HW];
    state_e                  state;
    logic                    in_fire;

    assign state   = row_q[0] ? EMIT : FILL;
    assign in_fire = s_valid && s_ready;

    // Horizontal pair max of the incoming beat, and vertical max against the parked row.
    always_comb begin
        for (int j = 0; j < HW; j++) begin
            hmax[j] = ($signed(s_data[(2*j)*ACC_W +: ACC_W]) > $signed(s_data[(2*j+1)*ACC_W +: ACC_W]))
                      ? $signed(s_data[(2*j)*ACC_W +: ACC_W])
                      : $signed(s_data[(2*j+1)*ACC_W +: ACC_W]);
            vmax[j] = (lb_q[col_q][j] > hmax[j]) ? lb_q[col_q][j] : hmax[j];
        end
    end

    // Next-state: beat counters, frame shift latch and the output register.
    always_comb begin
        col_d         = col_q;
        row_d         = row_q;
        shift_frame_d = shift_frame_q;
        m_valid_d     = m_valid_q;
        m_data_d      = m_data_q;
        last_d        = last_q;
        if (in_fire) begin
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
            if ((col_q == '0) && (row_q == '0)) begin
                shift_frame_d = cfg_shift;
            end
        end
        if (in_fire && (state == EMIT)) begin
            m_valid_d = 1'b1;
            for (int j = 0; j < HW; j++) begin
                m_data_d[j*N +: N] = requant(vmax[j], shift_frame_q);
            end
            last_d = (row_q == ROW_LAST) && (col_q == COL_LAST);
        end else if (m_ready) begin
            m_valid_d = 1'b0;
        end
    end

    // Control and output registers; reset restarts the frame and drops any pending output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q         <= '0;
            row_q         <= '0;
            shift_frame_q <= '0;
            m_valid_q     <= 1'b0;
            m_data_q      <= '0;
            last_q        <= 1'b0;
        end else begin
            col_q         <= col_d;
            row_q         <= row_d;
            shift_frame_q <= shift_frame_d;
            m_valid_q     <= m_valid_d;
            m_data_q      <= m_data_d;
            last_q        <= last_d;
        end
    end

    // Line buffer: always written on an even row before the odd row reads it, so no reset.
    always_ff @(posedge clk) begin
        if (in_fire && (state == FILL)) begin
            for (int j = 0; j < HW; j++) begin
                lb_q[col_q][j] <= hmax[j];
            end
        end
    end

    // Outputs: EMIT only accepts when the single output slot is free or draining.
    always_comb begin
        s_ready = 1'b1;
        if (state == EMIT) begin
            s_ready = !m_valid_q || m_ready;
        end
    end

    assign m_valid    = m_valid_q;
    assign m_data     = m_data_q;
    assign frame_done = m_valid_q && m_ready && last_q;

endmodule

// File: tb/tb_npu_pool_requant.sv
// Testbench for npu_pool_requant: constant vector table on a one-beat, two-row
// instance, plus randomized frames on the default instance scored against a
// frame-level pooling/requant model.
module tb_npu_pool_requant;
    localparam int W     = 8;
    localparam int N     = 2;
    localparam int ACC_W = 10;
    localparam int RB    = 4;
    localparam int ROWS  = 28;
    localparam int BPF   = RB * ROWS;
    localparam int OPF   = (ROWS / 2) * RB;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst_n;
    logic [3:0]           cfg_shift;
    logic                 s_valid, s_ready;
    logic [W*ACC_W-1:0]   s_data;
    logic                 m_valid, m_ready;
    logic [(W/2)*N-1:0]   m_data;
    logic                 frame_done;

    logic [3:0]           cfg_shift_s;
    logic                 s_valid_s, s_ready_s;
    logic [W*ACC_W-1:0]   s_data_s;
    logic                 m_valid_s, m_ready_s;
    logic [(W/2)*N-1:0]   m_data_s;
    logic                 frame_done_s;

    npu_pool_requant #(.W(W), .N(N), .BG(6), .ROW_BEATS(RB), .ROWS(ROWS)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_shift(cfg_shift),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
        .frame_done(frame_done)
    );

    npu_pool_requant #(.W(W), .N(N), .BG(6), .ROW_BEATS(1), .ROWS(2)) dut_s (
        .clk(clk), .rst_n(rst_n), .cfg_shift(cfg_shift_s),
        .s_valid(s_valid_s), .s_ready(s_ready_s), .s_data(s_data_s),
        .m_valid(m_valid_s), .m_ready(m_ready_s), .m_data(m_data_s),
        .frame_done(frame_done_s)
    );

    typedef struct {
        int a0; int a1; int b0; int b1; int sh; int e_tr; int e_rd;
    } vec_t;

    int         total = 0;
    int         bad   = 0;
    int         img [3][ROWS][RB*W];
    int         shifts [3];
    logic [7:0] exp_data [$];
    bit         exp_last [$];
    bit         mv_model = 1'b0;
    int         nout, nfd, last_cyc;
    vec_t       vt [12];

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Reference requant: ReLU, divide by 2^s (optionally rounded half-up), clamp.
    function automatic int requant_ref(input int v, input int s);
        int q;
        if (v <= 0) return 0;
`ifdef NPU_POOL_ROUND_EN
        q = (s > 0) ? (v + (1 << (s - 1))) / (1 << s) : v;
`else
        q = v / (1 << s);
`endif
        if (q > (1 << N) - 1) q = (1 << N) - 1;
        return q;
    endfunction

    function automatic logic [W*ACC_W-1:0] beat_data(input int b);
        int f, lb, r, c;
        logic [W*ACC_W-1:0] d;
        d  = '0;
        f  = b / BPF;
        lb = b % BPF;
        r  = lb / RB;
        c  = lb % RB;
        for (int i = 0; i < W; i++) d[i*ACC_W +: ACC_W] = ACC_W'(img[f][r][c*W + i]);
        return d;
    endfunction

    function automatic logic [W*ACC_W-1:0] pack2(input int l0, input int l1);
        logic [W*ACC_W-1:0] d;
        d = '0;
        d[0 +: ACC_W]     = ACC_W'(l0);
        d[ACC_W +: ACC_W] = ACC_W'(l1);
        return d;
    endfunction

    // Random images plus the expected pooled output stream for nf frames.
    task automatic gen_frames(input int nf);
        logic [7:0] e;
        int m, q;
        exp_data.delete();
        exp_last.delete();
        for (int f = 0; f < nf; f++) begin
            shifts[f] = int'($urandom_range(0, 5));
            for (int r = 0; r < ROWS; r++)
                for (int x = 0; x < RB*W; x++)
                    img[f][r][x] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 1023)) - 512
                                                               : int'($urandom_range(0, 47)) - 16;
            for (int rp = 0; rp < ROWS/2; rp++)
                for (int c = 0; c < RB; c++) begin
                    e = '0;
                    for (int j = 0; j < W/2; j++) begin
                        m = max2(max2(img[f][2*rp][c*W+2*j],   img[f][2*rp][c*W+2*j+1]),
                                 max2(img[f][2*rp+1][c*W+2*j], img[f][2*rp+1][c*W+2*j+1]));
                        q = requant_ref(m, shifts[f]);
                        e[j*N +: N] = 2'(q);
                    end
                    exp_data.push_back(e);
                    exp_last.push_back((rp == ROWS/2 - 1) && (c == RB - 1));
                end
        end
    endtask

    // Stream nbeats of the generated frames with random valid/ready, scoring each cycle.
    task automatic drive(input int nbeats, input int vpct, input int rpct,
                         input bit stall5, input bit drain);
        int b, cyc, stall, lb;
        bit stalled, sv, mr, odd, in_fire, out_fire;
        b = 0; cyc = 0; stall = 0; stalled = 1'b0;
        nout = 0; nfd = 0;
        while ((b < nbeats || (drain && exp_data.size() > 0)) && cyc < 5000) begin
            @(negedge clk);
            cyc++;
            lb  = b % BPF;
            odd = ((lb / RB) % 2) == 1;
            sv  = (b < nbeats) && ($urandom_range(0, 99) < vpct);
            if (stall5 && !stalled && lb == RB + 1) begin
                stall   = 5;
                stalled = 1'b1;
            end
            mr = (stall > 0) ? 1'b0 : ($urandom_range(0, 99) < rpct);
            if (stall > 0) stall--;
            s_valid   = sv;
            m_ready   = mr;
            s_data    = (b < nbeats) ? beat_data(b) : '0;
            cfg_shift = (lb == 0 && b < nbeats) ? 4'(shifts[b / BPF]) : 4'($urandom);
            #1;
            chk("s_ready", s_ready, (odd && mv_model && !mr) ? 0 : 1);
            chk("m_valid", m_valid, mv_model);
            out_fire = mv_model && mr;
            if (mv_model) begin
                chk("out_expected", exp_data.size() > 0, 1);
                if (exp_data.size() > 0) chk("m_data", m_data, exp_data[0]);
            end
            if (out_fire && exp_data.size() > 0) begin
                chk("frame_done", frame_done, exp_last[0]);
                if (frame_done) nfd++;
                nout++;
                void'(exp_data.pop_front());
                void'(exp_last.pop_front());
            end else begin
                chk("frame_done_idle", frame_done, 0);
            end
            in_fire = sv && s_ready;
            if (in_fire) b++;
            if (in_fire && odd) mv_model = 1'b1;
            else if (out_fire) mv_model = 1'b0;
        end
        last_cyc = cyc;
        chk("drive_complete", (b == nbeats) && (!drain || exp_data.size() == 0), 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int e;
        vt[0]  = '{5, 12, -3, 9, 2, 3, 3};
        vt[1]  = '{-7, -8, -20, -9, 0, 0, 0};
        vt[2]  = '{200, 1, 0, 0, 0, 3, 3};
        vt[3]  = '{6, 0, 0, 0, 2, 1, 2};
        vt[4]  = '{-1, -2, 1, 0, 0, 1, 1};
        vt[5]  = '{511, -512, 0, 0, 9, 0, 1};
        vt[6]  = '{7, 3, 2, 6, 1, 3, 3};
        vt[7]  = '{5, 4, 3, 2, 1, 2, 3};
        vt[8]  = '{100, -5, -5, -5, 15, 0, 0};
        vt[9]  = '{0, 0, 0, 0, 0, 0, 0};
        vt[10] = '{10, 9, 8, 7, 3, 1, 1};
        vt[11] = '{2, 0, -512, -512, 0, 2, 2};

        rst_n = 1'b0;
        cfg_shift = '0; s_valid = 1'b0; s_data = '0; m_ready = 1'b0;
        cfg_shift_s = '0; s_valid_s = 1'b0; s_data_s = '0; m_ready_s = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_s_ready", s_ready, 1);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_s_ready_small", s_ready_s, 1);
        chk("rst_m_valid_small", m_valid_s, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Idle: nothing comes out without input.
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            m_ready = 1'($urandom);
            #1;
            chk("idle_m_valid", m_valid, 0);
            chk("idle_s_ready", s_ready, 1);
        end

        // Vector table on the 1-beat x 2-row instance: every vector is one whole frame.
        m_ready_s = 1'b1;
        for (int k = 0; k < 12; k++) begin
`ifdef NPU_POOL_ROUND_EN
            e = vt[k].e_rd;
`else
            e = vt[k].e_tr;
`endif
            @(negedge clk);
            s_valid_s = 1'b1; cfg_shift_s = 4'(vt[k].sh); s_data_s = pack2(vt[k].a0, vt[k].a1);
            #1;
            chk("tbl_ready_row0", s_ready_s, 1);
            @(negedge clk);
            cfg_shift_s = 4'($urandom); s_data_s = pack2(vt[k].b0, vt[k].b1);
            #1;
            chk("tbl_ready_row1", s_ready_s, 1);
            @(negedge clk);
            s_valid_s = 1'b0;
            #1;
            chk("tbl_m_valid", m_valid_s, 1);
            chk("tbl_m_data", m_data_s, e);
            chk("tbl_frame_done", frame_done_s, 1);
        end

        // Two back-to-back frames under random flow control and a forced 5-cycle stall in row 1.
        gen_frames(2);
        drive(2*BPF, 80, 70, 1'b1, 1'b1);
        chk("bp_outputs", nout, 2*OPF);
        chk("bp_frame_dones", nfd, 2);

        // Full rate: one beat per cycle, frame wrap overlaps the last output handshake.
        gen_frames(2);
        drive(2*BPF, 100, 100, 1'b0, 1'b1);
        chk("fr_outputs", nout, 2*OPF);
        chk("fr_frame_dones", nfd, 2);
        chk("fr_cycles", last_cyc, 2*BPF + 1);

        // Reset with counters at row 5, col 2 and an output pending.
        gen_frames(1);
        drive(5*RB + 2, 100, 100, 1'b0, 1'b0);
        @(negedge clk);
        s_valid = 1'b0; m_ready = 1'b0;
        #1;
        chk("pre_rst_m_valid", m_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_m_valid", m_valid, 0);
        chk("mid_rst_m_data", m_data, 0);
        chk("mid_rst_s_ready", s_ready, 1);
        chk("mid_rst_frame_done", frame_done, 0);
        mv_model = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        gen_frames(1);
        drive(BPF, 85, 85, 1'b0, 1'b1);
        chk("post_rst_outputs", nout, OPF);
        chk("post_rst_frame_dones", nfd, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
